// File: rtl/knn_sorter_driver_if.sv
// Sorter-side bus of the KNN sorter driver: point streaming, readout sweep and clear.
// valid: one training point per cycle; the sorter has no backpressure and takes
// DATA_X2/DATA_Y2 at the clock edge closing every valid-high cycle.
interface knn_sorter_driver_if #(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 4,
   parameter int OUT_W  = 8
);
   logic              valid;
   logic [DATA_W-1:0] DATA_X1;
   logic [DATA_W-1:0] DATA_Y1;
   logic [DATA_W-1:0] DATA_X2;
   logic [DATA_W-1:0] DATA_Y2;
   logic              DONE;
   logic [SEL_W-1:0]  SEL;
   logic [OUT_W-1:0]  DATA_OUT;
   logic              sorter_clr;

   modport master (
      output valid, DATA_X1, DATA_Y1, DATA_X2, DATA_Y2, DONE, SEL, sorter_clr,
      input  DATA_OUT
   );

   modport slave (
      input  valid, DATA_X1, DATA_Y1, DATA_X2, DATA_Y2, DONE, SEL, sorter_clr,
      output DATA_OUT
   );
endinterface

// File: rtl/knn_sorter_driver.sv
// KNN sorter initiator: streams N training points from memory into the sorter,
// sweeps the K result slots into a local bank, then clears the sorter.
module knn_sorter_driver #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8,
   parameter int K      = 10,
   parameter int SEL_W  = 4,
   parameter int OUT_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   n_points,
   input  logic [DATA_W-1:0]   test_x,
   input  logic [DATA_W-1:0]   test_y,
   output logic                mem_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [2*DATA_W-1:0] mem_rdata,
   knn_sorter_driver_if.master srt,
   output logic                busy,
   output logic                done,
   input  logic [SEL_W-1:0]    res_sel,
   output logic [OUT_W-1:0]    res_data,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, CLR} state_t;

   state_t            state;
   logic [ADDR_W-1:0] n_lat;
   logic [DATA_W-1:0] x2_q;
   logic [DATA_W-1:0] y2_q;
   logic [OUT_W-1:0]  res_q [K];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         n_lat          <= '0;
         mem_en         <= 1'b0;
         mem_addr       <= '0;
         srt.valid      <= 1'b0;
         srt.DATA_X1    <= '0;
         srt.DATA_Y1    <= '0;
         srt.DONE       <= 1'b0;
         srt.SEL        <= '0;
         srt.sorter_clr <= 1'b0;
         x2_q           <= '0;
         y2_q           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         for (int i = 0; i < K; i++) res_q[i] <= '0;
      end else begin
         if (srt.valid) begin
            x2_q <= mem_rdata[2*DATA_W-1:DATA_W];
            y2_q <= mem_rdata[DATA_W-1:0];
         end
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  n_lat       <= n_points;
                  srt.DATA_X1 <= test_x;
                  srt.DATA_Y1 <= test_y;
                  busy        <= 1'b1;
                  if (n_points == '0) begin
                     state    <= DRAIN;
                     srt.DONE <= 1'b1;
                     srt.SEL  <= '0;
                  end else begin
                     state    <= STREAM;
                     mem_en   <= 1'b1;
                     mem_addr <= '0;
                  end
               end
            end
            STREAM: begin
               // Read data arrives one cycle after mem_en, so valid trails it by one.
               srt.valid <= mem_en;
               if (mem_en) begin
                  if (mem_addr == n_lat - ADDR_W'(1)) mem_en   <= 1'b0;
                  else                                mem_addr <= mem_addr + ADDR_W'(1);
               end
               if (srt.valid && !mem_en) begin
                  state    <= DRAIN;
                  srt.DONE <= 1'b1;
                  srt.SEL  <= '0;
               end
            end
            DRAIN: begin
               res_q[srt.SEL] <= srt.DATA_OUT;
               if (srt.SEL == SEL_W'(K - 1)) begin
                  state          <= CLR;
                  srt.DONE       <= 1'b0;
                  srt.SEL        <= '0;
                  srt.sorter_clr <= 1'b1;
               end else begin
                  srt.SEL <= srt.SEL + SEL_W'(1);
               end
            end
            CLR: begin
               state          <= IDLE;
               srt.sorter_clr <= 1'b0;
               mem_addr       <= '0;
               busy           <= 1'b0;
               done           <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Training point is forwarded straight from memory on the valid cycle, held afterwards.
   assign srt.DATA_X2 = srt.valid ? mem_rdata[2*DATA_W-1:DATA_W] : x2_q;
   assign srt.DATA_Y2 = srt.valid ? mem_rdata[DATA_W-1:0]        : y2_q;

   assign res_data  = (int'(res_sel) < K) ? res_q[res_sel] : '0;
   assign state_dbg = state;

endmodule

// File: tb/tb_knn_sorter_driver.sv
// Bench for knn_sorter_driver: memory and sorter stand-ins, cycle-exact protocol
// checks and a reference model of the captured result bank.
module tb_knn_sorter_driver;
   localparam int DATA_W = 16;
   localparam int ADDR_W = 8;
   localparam int K      = 10;
   localparam int SEL_W  = 4;
   localparam int OUT_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] n_points;
   logic [DATA_W-1:0] test_x, test_y;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata = '0;
   logic              busy, done;
   logic [SEL_W-1:0]  res_sel;
   logic [OUT_W-1:0]  res_data;
   logic [1:0]        state_dbg;

   logic [31:0]       mem [256];
   logic [7:0]        acc;
   logic [31:0]       exp_q [$];
   int                checks = 0;
   int                errors = 0;

   always #5 clk = ~clk;

   knn_sorter_driver_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .OUT_W(OUT_W)) srt ();

   knn_sorter_driver #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .K(K), .SEL_W(SEL_W), .OUT_W(OUT_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .n_points(n_points),
      .test_x(test_x), .test_y(test_y), .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .srt(srt), .busy(busy), .done(done),
      .res_sel(res_sel), .res_data(res_data), .state_dbg(state_dbg)
   );

   // Point memory with one cycle read latency
   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

   // Sorter stand-in: order-sensitive digest of the streamed points, offset per slot
   always @(posedge clk or posedge rst) begin
      if (rst)                 acc <= '0;
      else if (srt.sorter_clr) acc <= '0;
      else if (srt.valid)      acc <= 8'(acc * 8'd3 + (srt.DATA_X2[7:0] ^ srt.DATA_Y2[7:0]));
   end
   assign srt.DATA_OUT = srt.DONE ? 8'(acc + 8'd37 * {4'b0000, srt.SEL}) : 8'h00;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, expv, $time);
      end
   endtask

   function automatic logic [7:0] ref_digest(input int n);
      logic [7:0] a = '0;
      for (int i = 0; i < n; i++) a = 8'(a * 8'd3 + (mem[i][23:16] ^ mem[i][7:0]));
      return a;
   endfunction

   // Starts at a negedge and returns at the negedge of the done cycle (or after an abort).
   task automatic run_query(input int n, input logic [15:0] tx, input logic [15:0] ty,
                            input int busy_poke, input int abort_at);
      int         d0;
      bit         got_done = 1'b0;
      logic [5:0] ctl, ctl_exp;
      logic [31:0] pt;
      exp_q.delete();
      for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
      d0 = (n > 0) ? n + 2 : 1;
      n_points = ADDR_W'(n);
      test_x = tx;
      test_y = ty;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         if (c == abort_at) begin
            rst = 1'b1;
            #1;
            check_eq("abort_ctl", 32'({srt.valid, srt.DONE, busy, done}), 32'd0);
            check_eq("abort_res", 32'(res_data), 32'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         ctl     = {mem_en, srt.valid, srt.DONE, srt.sorter_clr, busy, done};
         ctl_exp = {c <= n, (c >= 2) && (c <= n + 1), (c >= d0) && (c < d0 + K),
                    c == d0 + K, c <= d0 + K, c == d0 + K + 1};
         check_eq("ctl", 32'(ctl), 32'(ctl_exp));
         if (mem_en)   check_eq("addr", 32'(mem_addr), 32'(c - 1));
         if (srt.DONE) check_eq("sel", 32'(srt.SEL), 32'(c - d0));
         check_eq("x1y1", {srt.DATA_X1, srt.DATA_Y1}, {tx, ty});
         if (srt.valid) begin
            if (exp_q.size() == 0) check_eq("extra_valid", 32'd1, 32'd0);
            else begin
               pt = exp_q.pop_front();
               check_eq("pt", {srt.DATA_X2, srt.DATA_Y2}, pt);
            end
         end
         if (c == busy_poke) begin
            start    = 1'b1;
            n_points = 8'd3;
            test_x   = ~tx;
         end
         if (c == busy_poke + 1) start = 1'b0;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check_eq("done_seen", 32'(got_done), 32'd1);
      check_eq("pts_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_results(input int n);
      logic [7:0] a = ref_digest(n);
      for (int k = 0; k < K; k++) begin
         res_sel = SEL_W'(k);
         #1;
         check_eq("res", 32'(res_data), 32'(8'(a + 8'(37 * k))));
      end
      res_sel = 4'd12;
      #1;
      check_eq("res_oob12", 32'(res_data), 32'd0);
      res_sel = 4'd15;
      #1;
      check_eq("res_oob15", 32'(res_data), 32'd0);
      @(negedge clk);
   endtask

   task automatic watch_no_done(input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      check_eq("stray_done", 32'(seen), 32'd0);
   endtask

   task automatic load_basic();
      for (int i = 0; i < 5; i++) mem[i] = {16'(i), 16'(-i)};
   endtask

   task automatic load_random();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      n_points = '0;
      test_x = '0;
      test_y = '0;
      res_sel = '0;
      load_random();
      #1;
      check_eq("rst_ctl", 32'({mem_en, srt.valid, srt.DONE, srt.sorter_clr, busy, done}), 32'd0);
      check_eq("rst_state", 32'(state_dbg), 32'd0);
      check_eq("rst_res", 32'(res_data), 32'd0);
      check_eq("rst_data", {srt.DATA_X1, srt.DATA_X2}, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      load_basic();
      run_query(5, 16'h0000, 16'h0000, 0, 0);
      check_results(5);

      run_query(0, 16'(($urandom)), 16'(($urandom)), 0, 0);
      check_results(0);

      mem[0] = {16'h8000, 16'h7FFF};
      mem[1] = {16'h7FFF, 16'h8000};
      run_query(2, 16'hFFFF, 16'h8000, 0, 0);
      check_results(2);

      load_random();
      run_query(6, 16'h1234, 16'hFEDC, 4, 0);
      watch_no_done(20);
      check_results(6);

      run_query(4, 16'h0A0A, 16'hB0B0, 0, 0);
      run_query(7, 16'h5555, 16'hAAAA, 0, 0);
      check_results(7);

      res_sel = 4'd2;
      run_query(8, 16'h0101, 16'h0202, 0, 4);
      watch_no_done(20);
      check_eq("post_abort_busy", 32'(busy), 32'd0);

      load_basic();
      run_query(5, 16'h0000, 16'h0000, 0, 0);
      check_results(5);

      repeat (6) begin
         load_random();
         run_query($urandom_range(1, 40), 16'(($urandom)), 16'(($urandom)), 0, 0);
         check_results(int'(n_points));
      end

      load_random();
      run_query(255, 16'h7FFF, 16'h8001, 0, 0);
      check_results(255);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
